// File: rtl/program_loader_if.sv
// Boot-stream and memory-write bundle between the program loader and its surroundings.
// slave is the loader's view; master is the view of whatever feeds the stream and watches the memories.
interface program_loader_if #(
    parameter int AW = 16
);
    logic           start;
    logic [31:0]    in_data;
    logic           in_valid;
    logic           in_ready;
    logic           imem_we;
    logic [AW-1:0]  imem_addr;
    logic [31:0]    imem_wdata;
    logic           dmem_we;
    logic [AW-1:0]  dmem_addr;
    logic [31:0]    dmem_wdata;
    logic           cpu_reset;
    logic           done;
    logic           error;
    logic [15:0]    loaded_count;

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata,
               dmem_we, dmem_addr, dmem_wdata,
               cpu_reset, done, error, loaded_count
    );

    modport master (
        output start, in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata,
               dmem_we, dmem_addr, dmem_wdata,
               cpu_reset, done, error, loaded_count
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: parses N, N instr words, M, M data words into imem/dmem and holds the CPU in reset until done.
// Write strobes appear one cycle after each accept; in_ready is a pure state decode, so in_valid gaps only stall.
module program_loader #(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 256,
    parameter int DMEM_BASE  = 512,
    parameter int AW         = 16
) (
    input  logic             clk,
    input  logic             reset,
    program_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ICOUNT, S_IWORDS, S_DCOUNT, S_DWORDS, S_DRAIN, S_RUN, S_ERROR
    } state_t;

    localparam logic [31:0]   IMEM_MAX = 32'(IMEM_WORDS);
    localparam logic [31:0]   DMEM_MAX = 32'(DMEM_WORDS);
    localparam logic [AW-1:0] DBASE    = AW'(DMEM_BASE / 4);

    state_t         r_state;
    logic [15:0]    r_target;
    logic [15:0]    r_idx;
    logic [15:0]    r_loaded;
    logic           r_imem_we;
    logic [AW-1:0]  r_imem_addr;
    logic [31:0]    r_imem_wdata;
    logic           r_dmem_we;
    logic [AW-1:0]  r_dmem_addr;
    logic [31:0]    r_dmem_wdata;

    logic           w_ready;
    logic           w_accept;
    logic           w_last;

    assign w_ready  = (r_state == S_ICOUNT) || (r_state == S_IWORDS) ||
                      (r_state == S_DCOUNT) || (r_state == S_DWORDS);
    assign w_accept = w_ready && bus.in_valid;
    assign w_last   = (r_idx == r_target - 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_target     <= '0;
            r_idx        <= '0;
            r_loaded     <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
        end else begin
            r_imem_we <= 1'b0;
            r_dmem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state  <= S_ICOUNT;
                        r_loaded <= '0;
                    end
                end
                S_ICOUNT: begin
                    if (w_accept) begin
                        r_idx <= '0;
                        if (bus.in_data > IMEM_MAX) begin
                            r_state <= S_ERROR;
                        end else if (bus.in_data == 32'd0) begin
                            r_state <= S_DCOUNT;
                        end else begin
                            r_state  <= S_IWORDS;
                            r_target <= bus.in_data[15:0];
                        end
                    end
                end
                S_IWORDS: begin
                    if (w_accept) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= AW'(r_idx);
                        r_imem_wdata <= bus.in_data;
                        r_loaded     <= r_loaded + 16'd1;
                        r_idx        <= r_idx + 16'd1;
                        if (w_last) r_state <= S_DCOUNT;
                    end
                end
                S_DCOUNT: begin
                    if (w_accept) begin
                        r_idx <= '0;
                        if (bus.in_data > DMEM_MAX) begin
                            r_state <= S_ERROR;
                        end else if (bus.in_data == 32'd0) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state  <= S_DWORDS;
                            r_target <= bus.in_data[15:0];
                        end
                    end
                end
                S_DWORDS: begin
                    if (w_accept) begin
                        r_dmem_we    <= 1'b1;
                        r_dmem_addr  <= DBASE + AW'(r_idx);
                        r_dmem_wdata <= bus.in_data;
                        r_loaded     <= r_loaded + 16'd1;
                        r_idx        <= r_idx + 16'd1;
                        if (w_last) r_state <= S_DRAIN;
                    end
                end
                // One cycle for the final write strobe to land before the CPU leaves reset.
                S_DRAIN: r_state <= S_RUN;
                S_RUN, S_ERROR: begin
                    if (bus.start) begin
                        r_state  <= S_ICOUNT;
                        r_loaded <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = w_ready;
    assign bus.imem_we      = r_imem_we;
    assign bus.imem_addr    = r_imem_addr;
    assign bus.imem_wdata   = r_imem_wdata;
    assign bus.dmem_we      = r_dmem_we;
    assign bus.dmem_addr    = r_dmem_addr;
    assign bus.dmem_wdata   = r_dmem_wdata;
    assign bus.cpu_reset    = (r_state != S_RUN);
    assign bus.done         = (r_state == S_RUN);
    assign bus.error        = (r_state == S_ERROR);
    assign bus.loaded_count = r_loaded;
endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized image loads against a write-list model of the boot stream.
module tb_program_loader;
    localparam int IMEM_WORDS = 128;
    localparam int DMEM_WORDS = 256;
    localparam int DMEM_BASE  = 512;
    localparam int AW         = 16;
    localparam int DBASE_W    = DMEM_BASE / 4;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] dat;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;
    int   gap_ph     = 0;
    logic [3:0] gap_pat = 4'b1001;

    logic [31:0] instr_q[$];
    logic [31:0] data_q[$];
    wr_t         imem_q[$];
    wr_t         dmem_q[$];

    program_loader_if #(.AW(AW)) bus ();

    program_loader #(
        .IMEM_WORDS(IMEM_WORDS),
        .DMEM_WORDS(DMEM_WORDS),
        .DMEM_BASE (DMEM_BASE),
        .AW        (AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.imem_we) imem_q.push_back('{addr: bus.imem_addr, dat: bus.imem_wdata});
        if (bus.dmem_we) dmem_q.push_back('{addr: bus.dmem_addr, dat: bus.dmem_wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the edge that accepted w.
    task automatic send(input logic [31:0] w, input bit gaps);
        bit acc;
        acc = 1'b0;
        for (int guard = 0; guard < 64 && !acc; guard++) begin
            bus.in_data  = w;
            bus.in_valid = gaps ? gap_pat[gap_ph] : 1'b1;
            gap_ph       = (gap_ph + 1) % 4;
            acc          = bus.in_valid && bus.in_ready;
            @(negedge clk);
        end
        if (!acc) begin
            compared++;
            mismatched++;
            $error("FAIL send_timeout observed=no_accept expected=accept word=%0h", w);
        end
    endtask

    task automatic fill_random(input int n, input int m);
        instr_q.delete();
        data_q.delete();
        for (int i = 0; i < n; i++) instr_q.push_back($urandom);
        for (int i = 0; i < m; i++) data_q.push_back($urandom);
    endtask

    task automatic run_image(input string tag, input bit gaps);
        int  n;
        int  m;
        wr_t e;
        n = instr_q.size();
        m = data_q.size();
        imem_q.delete();
        dmem_q.delete();
        pulse_start();
        chk({tag, "_start_ready"}, bus.in_ready, 1);
        chk({tag, "_start_cpurst"}, bus.cpu_reset, 1);
        chk({tag, "_start_cnt"}, bus.loaded_count, 0);
        send(n, gaps);
        foreach (instr_q[i]) send(instr_q[i], gaps);
        send(m, gaps);
        foreach (data_q[i]) send(data_q[i], gaps);
        bus.in_valid = 1'b0;
        chk({tag, "_drain_cpurst"}, bus.cpu_reset, 1);
        chk({tag, "_drain_done"}, bus.done, 0);
        @(negedge clk);
        chk({tag, "_run_cpurst"}, bus.cpu_reset, 0);
        chk({tag, "_run_done"}, bus.done, 1);
        chk({tag, "_run_ready"}, bus.in_ready, 0);
        chk({tag, "_run_cnt"}, bus.loaded_count, n + m);
        chk({tag, "_imem_writes"}, imem_q.size(), n);
        chk({tag, "_dmem_writes"}, dmem_q.size(), m);
        foreach (instr_q[k]) begin
            e = '{addr: 16'(k), dat: instr_q[k]};
            if (k < imem_q.size()) chk({tag, "_imem_wr"}, imem_q[k], e);
        end
        foreach (data_q[k]) begin
            e = '{addr: 16'(DBASE_W + k), dat: data_q[k]};
            if (k < dmem_q.size()) chk({tag, "_dmem_wr"}, dmem_q[k], e);
        end
        repeat (3) @(negedge clk);
        chk({tag, "_hold_cnt"}, bus.loaded_count, n + m);
        chk({tag, "_hold_done"}, bus.done, 1);
    endtask

    initial begin
        logic [31:0] sort_data[12];
        sort_data = '{55, 88, 0, 22, 77, 11, 99, 33, 110, 66, 121, 44};

        bus.start    = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        #1;
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_imem_we", bus.imem_we, 0);
        chk("rst_dmem_we", bus.dmem_we, 0);
        chk("rst_imem_addr", bus.imem_addr, 0);
        chk("rst_dmem_addr", bus.dmem_addr, 0);
        chk("rst_wdata", {bus.imem_wdata, bus.dmem_wdata}, 0);
        chk("rst_cpurst", bus.cpu_reset, 1);
        chk("rst_flags", {bus.done, bus.error}, 0);
        chk("rst_cnt", bus.loaded_count, 0);
        @(negedge clk);
        reset = 1'b0;

        // Bubble-sort sized image, continuous valid
        fill_random(23, 0);
        foreach (sort_data[i]) data_q.push_back(sort_data[i]);
        run_image("sort", 1'b0);

        // Same image with valid toggling 1,0,0,1 (also a reload from RUN)
        gap_ph = 0;
        run_image("gaps", 1'b1);

        // Zero counts
        instr_q.delete();
        data_q.delete();
        run_image("zero", 1'b0);

        // Instruction count overflow, then recovery
        pulse_start();
        send(IMEM_WORDS + 1, 1'b0);
        bus.in_valid = 1'b0;
        chk("ovf_error", bus.error, 1);
        chk("ovf_ready", bus.in_ready, 0);
        chk("ovf_cpurst", bus.cpu_reset, 1);
        chk("ovf_cnt", bus.loaded_count, 0);
        fill_random(5, 3);
        run_image("ovf_reload", 1'b0);

        // Data count overflow after two instructions; count holds in ERROR
        pulse_start();
        send(2, 1'b0);
        send($urandom, 1'b0);
        send($urandom, 1'b0);
        send(DMEM_WORDS + 1, 1'b0);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("dovf_error", bus.error, 1);
        chk("dovf_cnt", bus.loaded_count, 2);

        // Capacity boundary: full instruction and data images
        fill_random(IMEM_WORDS, DMEM_WORDS);
        run_image("full", 1'b0);

        // Async reset after five instructions
        pulse_start();
        send(23, 1'b0);
        for (int i = 0; i < 5; i++) send($urandom, 1'b0);
        bus.in_valid = 1'b0;
        chk("arst_pre_we", bus.imem_we, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_cpurst", bus.cpu_reset, 1);
        chk("arst_ready", bus.in_ready, 0);
        chk("arst_we", bus.imem_we, 0);
        chk("arst_cnt", bus.loaded_count, 0);
        #1 reset = 1'b0;
        fill_random(23, 12);
        run_image("arst_reload", 1'b0);

        // Randomized images with random gap use
        for (int t = 0; t < 4; t++) begin
            fill_random($urandom_range(1, IMEM_WORDS), $urandom_range(0, 40));
            run_image("rand", 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
